// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised RAM serving RV32 loads/stores over a valid/ready request and a one-cycle response.
// Optional DATA_MEM_MISALIGN_TRAP_EN: misaligned lh/lhu/sh/lw/sw are rejected instead of being aligned down.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        resp_err
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, RD, RMW, RESP} state_t;

    state_t state_q, state_d;

    logic [31:0]      mem [DEPTH_WORDS];
    logic             write_q, write_d;
    logic [2:0]       f3_q, f3_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       lane_q, lane_d;
    logic [15:0]      wdata_q, wdata_d;
    logic [31:0]      old_q, old_d;

    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             resp_err_q, resp_err_d;

    logic             accept;
    logic             f3_ok;
    logic             req_err;
    logic [1:0]       lane_in;
    logic [31:0]      rd_word;
    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [31:0]      mem_wdata;

    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:IDX_W+2];

    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] f3,
                                                input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [15:0] nw,
                                                input logic is_half, input logic [1:0] lane);
        logic [31:0] r;
        r = old;
        if (is_half) begin
            if (lane[1]) r[31:16] = nw;
            else         r[15:0]  = nw;
        end else begin
            case (lane)
                2'd0:    r[7:0]   = nw[7:0];
                2'd1:    r[15:8]  = nw[7:0];
                2'd2:    r[23:16] = nw[7:0];
                default: r[31:24] = nw[7:0];
            endcase
        end
        return r;
    endfunction

    // Request decode: legality and the lane actually used for the access.
    always_comb begin
        accept = req_valid && (state_q == IDLE) && !reset;
        if (req_write) f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        else           f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                               (funct3 == 3'b100) || (funct3 == 3'b101);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
        req_err = !f3_ok || ((funct3[1:0] == 2'b01) && addr[0]) ||
                  ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        lane_in = addr[1:0];
`else
        req_err = !f3_ok;
        case (funct3[1:0])
            2'b01:   lane_in = {addr[1], 1'b0};
            2'b10:   lane_in = 2'b00;
            default: lane_in = addr[1:0];
        endcase
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)                state_d = RESP;
                    else if (!req_write)        state_d = RD;
                    else if (funct3 == 3'b010)  state_d = RESP;
                    else                        state_d = RD;
                end
            end
            RD:      state_d = write_q ? RMW : RESP;
            RMW:     state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rd_word   = mem[idx_q];

        write_d = write_q;
        f3_d    = f3_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        wdata_d = wdata_q;
        if (accept) begin
            write_d = req_write;
            f3_d    = funct3;
            idx_d   = addr[IDX_W+1:2];
            lane_d  = lane_in;
            wdata_d = wdata[15:0];
        end
        old_d = (state_q == RD) ? rd_word : old_q;

        // Full-word stores go straight in at accept; partial stores write the merged word in RMW.
        mem_we    = 1'b0;
        mem_waddr = idx_q;
        mem_wdata = store_merge(old_q, wdata_q, f3_q[0], lane_q);
        if (accept && !req_err && req_write && (funct3 == 3'b010)) begin
            mem_we    = 1'b1;
            mem_waddr = addr[IDX_W+1:2];
            mem_wdata = wdata;
        end else if (state_q == RMW) begin
            mem_we = 1'b1;
        end

        resp_valid_d = (state_d == RESP);
        resp_err_d   = accept && req_err;
        rdata_d      = ((state_q == RD) && !write_q) ? load_extend(rd_word, f3_q, lane_q) : 32'h0;
    end

    always_ff @(posedge clk) begin
        write_q <= write_d;
        f3_q    <= f3_d;
        idx_q   <= idx_d;
        lane_q  <= lane_d;
        wdata_q <= wdata_d;
        old_q   <= old_d;
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit RAM words (power of two).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  CPU memory request present.
REQ-005 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port funct3  input  3  access size/sign (load 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store 000 sb, 001 sh, 010 sw).
REQ-008 SHALL have port addr  input  32  byte address.
REQ-009 SHALL have port wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rdata  output  32  load result, sign/zero extended; 0 for stores and errors.
REQ-012 SHALL have port resp_err  output  1  request rejected, qualified by resp_valid.

Function
REQ-013 SHALL implement FSM states IDLE, RD, RMW, RESP; req_ready = 1 only in IDLE.
REQ-014 SHALL accept a request in cycle N when req_valid & req_ready; inputs sampled only in that cycle.
REQ-015 Loads SHALL go IDLE(N) -> RD(N+1, synchronous RAM read) -> RESP(N+2) -> IDLE; resp_valid high in N+2.
REQ-016 sw SHALL write the full word in cycle N, then RESP(N+1) -> IDLE.
REQ-017 sb/sh SHALL read-modify-write: IDLE(N) -> RD(N+1) -> RMW(N+2, merged word written) -> RESP(N+3) -> IDLE; only the addressed byte/halfword lanes change.
REQ-018 Byte lane SHALL be addr[1:0]; halfword lane addr[1]; word index addr[2+log2(DEPTH_WORDS)-1:2]; upper address bits ignored (wrap modulo DEPTH_WORDS).
REQ-019 lb/lh SHALL sign-extend from bit 7/15 of the selected lane; lbu/lhu SHALL zero-extend.
REQ-020 Unsupported funct3 (load 011/110/111, store >= 011) SHALL perform no RAM access and go RESP at N+1 with resp_err = 1, rdata = 0.
REQ-021 resp_valid, rdata, resp_err SHALL be registered and valid only in the RESP cycle; rdata = 0 and resp_err = 0 otherwise.
REQ-022 A request presented while req_ready = 0 SHALL be ignored; the CPU holds it until accepted.
REQ-023 Back-to-back requests: next request SHALL be accepted no earlier than the cycle after RESP.

Reset
REQ-024 Reset SHALL force state IDLE, req_ready = 1, resp_valid = 0, rdata = 0, resp_err = 0, immediately and independent of clk.
REQ-025 Reset mid-operation SHALL abandon the request; an RMW not yet in RMW state SHALL not write; RAM contents SHALL not be cleared.

Configuration
REQ-026 Macro DATA_MEM_MISALIGN_TRAP_EN defined: lh/lhu/sh with addr[0] = 1 or lw/sw with addr[1:0] != 0 SHALL skip RAM access and go RESP at N+1 with resp_err = 1, rdata = 0.
REQ-027 Macro undefined: misaligned accesses SHALL be performed with offending low address bits forced to 0, resp_err = 0.

Verification
REQ-028 sw addr 0x10 wdata 0xDEADBEEF, then lw 0x10 -> store resp_valid at N+1; load resp_valid at N+2, rdata 0xDEADBEEF, resp_err 0.
REQ-029 sb addr 0x11 wdata 0x80 onto word 0x11223344, then lb 0x11 / lbu 0x11 -> word 0x11228044; lb rdata 0xFFFFFF80, lbu rdata 0x00000080; sb resp at N+3.
REQ-030 sh addr 0x22 wdata 0x7FFF, then lh 0x22 -> rdata 0x00007FFF; lower halfword of word 0x20 unchanged.
REQ-031 lw addr 0x03 -> macro defined: resp_err 1, rdata 0 at N+1; undefined: rdata = word at 0x00, resp_err 0 at N+2.
REQ-032 Assert reset during RD of an sb -> state IDLE, req_ready 1, no resp_valid, target word unchanged on later lw.
REQ-033 Load funct3 011 and addr DEPTH_WORDS*4 + 0x4 -> funct3 011 gives resp_err 1 at N+1; wrapped address reads word index 1.
